wide_adder_sequencer: RTL and testbench

Multi-cycle wide adder. It adds two `NUMB_BITS*NUM_CHUNKS`-bit operands by passing them through one `adder_nbit` instance, one `NUMB_BITS`-wide chunk per clock, least-significant chunk first. Each chunk's carry out is registered and fed back as the carry in of the next chunk. It sits between a requester (start/done handshake) and the shared ripple adder, trading latency for area on wide additions.

---
 rtl/wide_adder_sequencer.sv | 142 ++++++++++++++
 tb/tb_wide_adder_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wide_adder_sequencer.sv
// Multi-cycle wide adder: streams NUM_CHUNKS chunks of the operands through one
// NUMB_BITS ripple adder, least-significant chunk first, carrying between chunks.

module adder_nbit #(
    parameter int NUMB_BITS = 4
) (
    input  logic [NUMB_BITS-1:0] a,
    input  logic [NUMB_BITS-1:0] b,
    input  logic                 carry_in,
    output logic [NUMB_BITS-1:0] sum,
    output logic                 overflow
);

    logic carry;

    always_comb begin
        carry = carry_in;
        sum   = '0;
        for (int i = 0; i < NUMB_BITS; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        overflow = carry;
    end

endmodule

// state | meaning
// IDLE  | waiting for start; last result held on sum_out/overflow
// ADD   | one chunk added and committed per cycle, idx selects the chunk
// DONE  | result complete, done pulses; a start here is accepted back-to-back
module wide_adder_sequencer #(
    parameter int NUMB_BITS  = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic [NUMB_BITS*NUM_CHUNKS-1:0] a_in,
    input  logic [NUMB_BITS*NUM_CHUNKS-1:0] b_in,
    input  logic                            carry_in,
    output logic                            busy,
    output logic                            done,
    output logic [NUMB_BITS*NUM_CHUNKS-1:0] sum_out,
    output logic                            overflow
);

    localparam int W     = NUMB_BITS * NUM_CHUNKS;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               c_q, c_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               ovf_q, ovf_d;

    logic [NUMB_BITS-1:0] chunk_a, chunk_b, chunk_sum;
    logic                 chunk_co;

    assign chunk_a = a_q[idx_q*NUMB_BITS +: NUMB_BITS];
    assign chunk_b = b_q[idx_q*NUMB_BITS +: NUMB_BITS];

    adder_nbit #(.NUMB_BITS(NUMB_BITS)) u_adder (
        .a        (chunk_a),
        .b        (chunk_b),
        .carry_in (c_q),
        .sum      (chunk_sum),
        .overflow (chunk_co)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = carry_in;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                sum_d[idx_q*NUMB_BITS +: NUMB_BITS] = chunk_sum;
                c_d = chunk_co;
                if (idx_q == IDX_LAST) begin
                    ovf_d   = chunk_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status comes from registered state only, so no input-to-output path exists.
    assign busy     = (state_q == ADD);
    assign done     = (state_q == DONE);
    assign sum_out  = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// Self-checking bench for wide_adder_sequencer: directed handshake/reset cases
// plus randomized operands against an arithmetic reference.

module tb_wide_adder_sequencer;

    localparam int NB = 4;
    localparam int NC = 4;
    localparam int W  = NB * NC;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    wide_adder_sequencer #(.NUMB_BITS(NB), .NUM_CHUNKS(NC)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".sum"}, 32'(sum_out), 32'd0);
        chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    endtask

    // Called at a negedge; returns just after the accepting edge with operands scrambled.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        start    = 1'b1;
        a_in     = a;
        b_in     = b;
        carry_in = cin;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        carry_in = 1'($urandom);
    endtask

    // Follows busy/done cycle by cycle and checks the result; returns at the negedge inside DONE.
    task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input bit pulse_mid);
        logic [W:0] expv;
        int busy_cnt;
        int done_cnt;
        expv = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i <= NC; i++) begin
            @(negedge clk);
            chk({tag, ".busy_t"}, 32'(busy), 32'(i < NC));
            chk({tag, ".done_t"}, 32'(done), 32'(i == NC));
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (pulse_mid && i == 1) begin
                start = 1'b1;
                a_in  = W'(16'h0001);
                b_in  = W'(16'h0001);
            end
            if (pulse_mid && i == 2) start = 1'b0;
        end
        chk({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(NC));
        chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, ".sum"}, 32'(sum_out), 32'(expv[W-1:0]));
        chk({tag, ".ovf"}, 32'(overflow), 32'(expv[W]));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;

        // Reset with start asserted and random operands
        n_rst    = 1'b0;
        start    = 1'b1;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        carry_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_outputs_zero("reset");
        end
        start = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("post_reset_idle");

        // Plain add, then hold check
        start_op(16'h1234, 16'h0FFF, 1'b0);
        wait_result("plain", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold.sum", 32'(sum_out), 32'h2233);
            chk("hold.ovf", 32'(overflow), 32'd0);
            chk("hold.busy", 32'(busy), 32'd0);
            chk("hold.done", 32'(done), 32'd0);
        end

        // Full carry ripple
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_result("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        start_op(16'h0000, 16'hFFFF, 1'b1);
        wait_result("ripple2", 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);

        // Start during ADD ignored, then back-to-back start during DONE
        start_op(16'h1234, 16'h0FFF, 1'b0);
        wait_result("ignore_mid", 16'h1234, 16'h0FFF, 1'b0, 1'b1);
        start_op(16'h0001, 16'h0002, 1'b0);
        wait_result("b2b", 16'h0001, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);

        // Reset mid-operation, checked before the next edge
        start_op(16'hABCD, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk_outputs_zero("mid_reset_async");
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_outputs_zero("mid_reset_hold");
        end
        start = 1'b0;
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_outputs_zero("after_release");
        end
        start_op(16'h00FF, 16'h0001, 1'b0);
        wait_result("post_reset_op", 16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized operands, mixing idle gaps with back-to-back starts
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (n % 8 == 0) ra = '1;
            start_op(ra, rb, rc);
            wait_result("rand", ra, rb, rc, 1'b0);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                chk("rand.idle_busy", 32'(busy), 32'd0);
                chk("rand.idle_done", 32'(done), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
